// File: rtl/multi_linebuffer.sv
// -----------------------------------------------------------------------------
// multi_linebuffer
//   N-way ring of line buffers between the sprite/tile draw engine and the
//   pixel output stage. One buffer is on screen, the next one in the ring is the
//   draw target, and the rest are spares. A flip rotates the ring. The buffer
//   that leaves the screen is then wiped by a built-in clear engine while the
//   other buffers keep working. After reset every buffer is wiped in order.
//
// Ports
//   clk_draw    sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   rd_addr     pixel address into the on-screen buffer
//   rd_colour   pixel read data, one cycle after rd_addr
//   wr_addr     word address into the draw buffer
//   wr_we       per-lane write enables
//   wr_colour   write data, lane k at [k*COLOUR_W +: COLOUR_W]
//   flip_req    single-cycle request to rotate the ring
//   flip_ack    pulses in the cycle a rotation is performed
//   draw_ready  draw buffer is clean and accepts writes
//   clear_busy  clear engine is active (post-reset init or release clear)
//   on_idx      index of the on-screen buffer
//   draw_idx    index of the draw buffer
// -----------------------------------------------------------------------------
module multi_linebuffer #(
  parameter int                  NUM_BUFS     = 3,
  parameter int                  LANES        = 8,
  parameter int                  COLOUR_W     = 9,
  parameter int                  WORDS        = 512,
  parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = '0,
  localparam int WA = $clog2(WORDS),
  localparam int LW = $clog2(LANES),
  localparam int PA = WA + LW,
  localparam int BI = $clog2(NUM_BUFS)
) (
  input  logic                      clk_draw,
  input  logic                      rst_n,
  input  logic [PA-1:0]             rd_addr,
  output logic [COLOUR_W-1:0]       rd_colour,
  input  logic [WA-1:0]             wr_addr,
  input  logic [LANES-1:0]          wr_we,
  input  logic [LANES*COLOUR_W-1:0] wr_colour,
  input  logic                      flip_req,
  output logic                      flip_ack,
  output logic                      draw_ready,
  output logic                      clear_busy,
  output logic [BI-1:0]             on_idx,
  output logic [BI-1:0]             draw_idx
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CLEAR} state_e;

  localparam logic [BI-1:0] LAST_BUF  = BI'(NUM_BUFS - 1);
  localparam logic [WA-1:0] LAST_WORD = WA'(WORDS - 1);

  // Ring successor; NUM_BUFS need not be a power of two, so wrap explicitly.
  function automatic logic [BI-1:0] inc_idx(input logic [BI-1:0] idx);
    return (idx == LAST_BUF) ? '0 : idx + 1'b1;
  endfunction

  state_e        state_q, state_d;
  logic [BI-1:0] head_q,  head_d;
  logic [BI-1:0] tgt_q,   tgt_d;    // buffer the clear engine is wiping
  logic [WA-1:0] cnt_q,   cnt_d;    // clear engine word counter
  logic          pend_q,  pend_d;   // a flip is waiting for the engine to go idle
  logic          flip_exec;
  logic [COLOUR_W-1:0] rd_colour_q;

  logic [LANES-1:0][COLOUR_W-1:0] mem [NUM_BUFS][WORDS];

  // ---------------------------------------------------------------------------
  // Clear engine and flip control
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q | flip_req;   // extra requests merge into one pending flip
    flip_exec = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_WORD) begin
          cnt_d = '0;
          if (tgt_q == LAST_BUF) state_d = ST_IDLE;
          else                   tgt_d   = inc_idx(tgt_q);
        end
      end
      ST_IDLE: begin
        if (pend_q) begin
          // A request in this same cycle is absorbed by this rotation.
          flip_exec = 1'b1;
          pend_d    = 1'b0;
          head_d    = inc_idx(head_q);
          tgt_d     = head_q;            // outgoing on-screen buffer gets wiped
          cnt_d     = '0;
          state_d   = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_WORD) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_draw or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      head_q  <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  assign on_idx     = head_q;
  assign draw_idx   = inc_idx(head_q);
  assign clear_busy = (state_q != ST_IDLE);
  assign flip_ack   = flip_exec;
  // With two buffers the new draw buffer is the one being wiped; with three or
  // more it is an already-clean spare and drawing never stalls.
  assign draw_ready = (state_q == ST_IDLE) ||
                      ((state_q == ST_CLEAR) && (tgt_q != draw_idx));

  // ---------------------------------------------------------------------------
  // Buffer storage: clear-engine writes and draw writes never hit the same
  // buffer in one cycle (draw writes are gated off whenever they could).
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; its contents are defined by the
  // post-reset init pass instead, which keeps it mappable to RAM.
  always_ff @(posedge clk_draw) begin
    if (clear_busy) mem[tgt_q][cnt_q] <= {LANES{CLEAR_COLOUR}};
    for (int k = 0; k < LANES; k++) begin
      if (wr_we[k] && draw_ready)
        mem[draw_idx][wr_addr][k] <= wr_colour[k*COLOUR_W +: COLOUR_W];
    end
  end

  // Read samples the pre-edge head, so a read in a flip cycle sees the old
  // on-screen buffer.
  always_ff @(posedge clk_draw or negedge rst_n) begin
    if (!rst_n) rd_colour_q <= '0;
    else        rd_colour_q <= mem[head_q][rd_addr[PA-1:LW]][rd_addr[LW-1:0]];
  end

  assign rd_colour = rd_colour_q;

endmodule

// File: tb/tb_multi_linebuffer.sv
// -----------------------------------------------------------------------------
// tb_multi_linebuffer
//   Directed bench for multi_linebuffer: a 3-buffer instance exercises init,
//   flips, merged requests, write-on-flip and mid-clear reset; a 2-buffer
//   instance exercises the draw stall and write dropping.
// -----------------------------------------------------------------------------
module tb_multi_linebuffer;

  logic clk_draw = 1'b0;
  always #5 clk_draw = ~clk_draw;

  int n_total = 0;
  int n_bad   = 0;

  // 3-buffer instance
  logic        rst3 = 1'b0;
  logic [11:0] rd_addr3 = '0;
  logic [8:0]  rd_colour3;
  logic [8:0]  wr_addr3 = '0;
  logic [7:0]  wr_we3 = '0;
  logic [71:0] wr_colour3 = '0;
  logic        flip_req3 = 1'b0;
  logic        flip_ack3, draw_ready3, clear_busy3;
  logic [1:0]  on_idx3, draw_idx3;

  // 2-buffer instance
  logic        rst2 = 1'b0;
  logic [11:0] rd_addr2 = '0;
  logic [8:0]  rd_colour2;
  logic [8:0]  wr_addr2 = '0;
  logic [7:0]  wr_we2 = '0;
  logic [71:0] wr_colour2 = '0;
  logic        flip_req2 = 1'b0;
  logic        flip_ack2, draw_ready2, clear_busy2;
  logic [0:0]  on_idx2, draw_idx2;

  multi_linebuffer #(.NUM_BUFS(3)) dut3 (
    .clk_draw(clk_draw), .rst_n(rst3),
    .rd_addr(rd_addr3), .rd_colour(rd_colour3),
    .wr_addr(wr_addr3), .wr_we(wr_we3), .wr_colour(wr_colour3),
    .flip_req(flip_req3), .flip_ack(flip_ack3),
    .draw_ready(draw_ready3), .clear_busy(clear_busy3),
    .on_idx(on_idx3), .draw_idx(draw_idx3)
  );

  multi_linebuffer #(.NUM_BUFS(2)) dut2 (
    .clk_draw(clk_draw), .rst_n(rst2),
    .rd_addr(rd_addr2), .rd_colour(rd_colour2),
    .wr_addr(wr_addr2), .wr_we(wr_we2), .wr_colour(wr_colour2),
    .flip_req(flip_req2), .flip_ack(flip_ack2),
    .draw_ready(draw_ready2), .clear_busy(clear_busy2),
    .on_idx(on_idx2), .draw_idx(draw_idx2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_draw);
    #1;
  endtask

  int n, acks, ack_at, idle_at;
  bit ready_dropped;

  initial begin
    // ------------------------------------------------------------ reset state
    repeat (3) tick();
    check("rst_busy",  clear_busy3, 1);
    check("rst_ready", draw_ready3, 0);
    check("rst_on",    on_idx3,     0);
    check("rst_draw",  draw_idx3,   1);
    check("rst_ack",   flip_ack3,   0);
    check("rst_rd",    rd_colour3,  0);

    // ------------------------------------------------------------ init pass
    rst3 = 1'b1;
    n = 0;
    while (clear_busy3 && n < 3000) begin tick(); n++; end
    check("init_cycles", n, 1536);
    check("init_ready",  draw_ready3, 1);
    check("init_on",     on_idx3,     0);
    check("init_draw",   draw_idx3,   1);
    rd_addr3 = 12'd42;   tick(); check("init_rd42",   rd_colour3, 0);
    rd_addr3 = 12'hFFF;  tick(); check("init_rdlast", rd_colour3, 0);

    // ------------------------------------------------------------ write + flip
    wr_addr3 = 9'd5;
    wr_we3   = 8'hFF;
    for (int k = 0; k < 8; k++) wr_colour3[k*9 +: 9] = 9'(k + 1);
    tick();
    wr_we3 = '0;
    flip_req3 = 1'b1; tick(); flip_req3 = 1'b0;
    check("flip1_ack",    flip_ack3, 1);
    check("flip1_on_pre", on_idx3,   0);
    tick();
    check("flip1_ack_off", flip_ack3,   0);
    check("flip1_on",      on_idx3,     1);
    check("flip1_draw",    draw_idx3,   2);
    check("flip1_busy",    clear_busy3, 1);
    rd_addr3 = 12'd42;
    n = 0; ready_dropped = 1'b0;
    while (clear_busy3 && n < 2000) begin
      if (!draw_ready3) ready_dropped = 1'b1;
      tick(); n++;
      if (n == 1) check("flip1_rd42", rd_colour3, 3);
    end
    check("clear1_cycles", n, 512);
    check("clear1_ready_held", ready_dropped, 0);

    // ------------------------------------------------------------ merged requests
    flip_req3 = 1'b1; tick(); flip_req3 = 1'b0;
    check("flip2_ack", flip_ack3, 1);
    tick();                                // rotation: on=2, buffer 1 wiped
    acks = 0; ack_at = -1; idle_at = -1;
    for (int i = 0; i < 1200; i++) begin
      flip_req3 = (i == 10 || i == 20);
      tick();
      if (flip_ack3) begin acks++; if (ack_at < 0) ack_at = i; end
      if (!clear_busy3 && idle_at < 0) idle_at = i;
    end
    flip_req3 = 1'b0;
    check("merge_acks",     acks,    1);
    check("merge_ack_idle", ack_at,  idle_at);
    check("merge_ack_at",   ack_at,  511);
    check("merge_on",       on_idx3, 0);
    check("merge_draw",     draw_idx3, 1);
    check("merge_idle",     clear_busy3, 0);

    // ------------------------------------------------------------ write in flip cycle
    flip_req3 = 1'b1; tick(); flip_req3 = 1'b0;
    wr_addr3   = 9'd7;
    wr_we3     = 8'b0000_0100;
    wr_colour3 = '0;
    wr_colour3[2*9 +: 9] = 9'h0AB;
    check("flip3_ack", flip_ack3, 1);
    tick();
    wr_we3 = '0;
    check("flip3_on", on_idx3, 1);
    rd_addr3 = 12'd58; tick(); check("flip3_rd58", rd_colour3, 9'h0AB);
    rd_addr3 = 12'd42; tick(); check("flip3_rd42_wiped", rd_colour3, 0);
    rd_addr3 = 12'd57; tick(); check("flip3_rd57", rd_colour3, 0);

    // ------------------------------------------------------------ reset mid-clear
    rd_addr3 = 12'd58;
    flip_req3 = 1'b1; tick(); flip_req3 = 1'b0;
    repeat (5) tick();
    check("pre_rst_rd",   rd_colour3,  9'h0AB);
    check("pre_rst_busy", clear_busy3, 1);
    rst3 = 1'b0;
    #1;
    check("mid_rst_busy",  clear_busy3, 1);
    check("mid_rst_ready", draw_ready3, 0);
    check("mid_rst_on",    on_idx3,     0);
    check("mid_rst_draw",  draw_idx3,   1);
    check("mid_rst_ack",   flip_ack3,   0);
    check("mid_rst_rd",    rd_colour3,  0);
    repeat (2) tick();
    rst3 = 1'b1;
    n = 0; acks = 0;
    while (clear_busy3 && n < 3000) begin tick(); n++; if (flip_ack3) acks++; end
    check("reinit_cycles", n, 1536);
    repeat (20) begin tick(); if (flip_ack3) acks++; end
    check("reinit_no_ack", acks,    0);
    check("reinit_on",     on_idx3, 0);

    // ------------------------------------------------------------ two buffers
    rst2 = 1'b1;
    n = 0;
    while (clear_busy2 && n < 3000) begin tick(); n++; end
    check("b2_init_cycles", n, 1024);
    check("b2_init_ready",  draw_ready2, 1);
    flip_req2 = 1'b1; tick(); flip_req2 = 1'b0;
    check("b2_flip1_ack", flip_ack2, 1);
    tick();
    check("b2_flip1_on",    on_idx2,     1);
    check("b2_flip1_draw",  draw_idx2,   0);
    check("b2_stall_ready", draw_ready2, 0);
    wr_addr2   = 9'd3;
    wr_colour2 = {8{9'h1FF}};
    n = 0;
    while (!draw_ready2 && n < 2000) begin
      wr_we2 = (n == 500) ? 8'hFF : 8'h00;
      tick(); n++;
    end
    wr_we2 = '0;
    check("b2_stall_cycles", n, 512);
    wr_addr2   = 9'd4;
    wr_we2     = 8'b0000_0010;
    wr_colour2 = '0;
    wr_colour2[1*9 +: 9] = 9'h155;
    tick();
    wr_we2 = '0;
    flip_req2 = 1'b1; tick(); flip_req2 = 1'b0;
    check("b2_flip2_ack", flip_ack2, 1);
    tick();
    check("b2_flip2_on", on_idx2, 0);
    rd_addr2 = 12'd24; tick(); check("b2_dropped_l0", rd_colour2, 0);
    rd_addr2 = 12'd31; tick(); check("b2_dropped_l7", rd_colour2, 0);
    rd_addr2 = 12'd33; tick(); check("b2_kept_wr",    rd_colour2, 9'h155);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
